// File: rtl/bfcpu_mem_arbiter_pkg.sv
// rtl/bfcpu_mem_arbiter_pkg.sv - shared state, grant and direction encodings for the bfcpu memory arbiter
`ifndef ARB_STATE_VH
`define ARB_STATE_VH
`define ARB_IDLE    2'd0
`define ARB_ISSUE   2'd1
`define ARB_CAPTURE 2'd2
`define ARB_DONE    2'd3
`define GRANT_I     1'b0
`define GRANT_D     1'b1
`endif

`ifndef DIRECTION_VH
`define DIRECTION_VH
`define DIRECTION_READ  1'b0
`define DIRECTION_WRITE 1'b1
`endif

package bfcpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = `ARB_IDLE,
        ST_ISSUE   = `ARB_ISSUE,
        ST_CAPTURE = `ARB_CAPTURE,
        ST_DONE    = `ARB_DONE
    } arb_state_t;

    localparam int DATA_W = 8;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - 2-way request picker; BFCPU_ARB_DATA_PRIO_EN selects fixed data priority
module arb_rr2 (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

`ifdef BFCPU_ARB_DATA_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = req_d ? `GRANT_D : `GRANT_I;
`else
    // On a tie the port that was not served last wins, so neither side can starve.
    always_comb begin
        grant = `GRANT_I;
        if (req_i && req_d) begin
            grant = (last_grant == `GRANT_D) ? `GRANT_I : `GRANT_D;
        end else if (req_d) begin
            grant = `GRANT_D;
        end
    end
`endif

endmodule

// File: rtl/bfcpu_mem_arbiter.sv
// rtl/bfcpu_mem_arbiter.sv - shares one single-port RAM between bfcpu I and D ports (BFCPU_ARB_DATA_PRIO_EN: data priority)
module bfcpu_mem_arbiter
    import bfcpu_mem_arbiter_pkg::*;
#(
    parameter logic [7:0] D_PAGE = 8'hFF,
    parameter int         AW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [15:0]       i_addr,
    output logic              i_ack,
    output logic [7:0]        i_rdata,
    input  logic              d_req,
    input  logic              d_dir,
    input  logic [7:0]        d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_ack,
    output logic [7:0]        d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    arb_state_t  state, state_nxt;
    logic        grant, grant_nxt;
    logic        last_grant, last_grant_nxt;
    logic        acc_wr, acc_wr_nxt;
    logic        pick;
    logic        m_en_nxt, m_we_nxt;
    logic [AW-1:0] m_addr_nxt;
    logic [7:0]  m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic        i_ack_nxt, d_ack_nxt;

    arb_rr2 u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        acc_wr_nxt     = acc_wr;
        m_en_nxt       = m_en;
        m_we_nxt       = m_we;
        m_addr_nxt     = m_addr;
        m_wdata_nxt    = m_wdata;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        i_ack_nxt      = i_ack;
        d_ack_nxt      = d_ack;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    acc_wr_nxt     = (pick == `GRANT_D) && (d_dir == `DIRECTION_WRITE);
                    m_en_nxt       = 1'b1;
                    m_we_nxt       = (pick == `GRANT_D) && (d_dir == `DIRECTION_WRITE);
                    m_addr_nxt     = (pick == `GRANT_D) ? AW'({D_PAGE, d_addr}) : AW'(i_addr);
                    m_wdata_nxt    = d_wdata;
                    state_nxt      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_en_nxt  = 1'b0;
                m_we_nxt  = 1'b0;
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (grant == `GRANT_I) begin
                    i_rdata_nxt = m_rdata;
                    i_ack_nxt   = 1'b1;
                end else begin
                    d_ack_nxt = 1'b1;
                    if (!acc_wr) begin
                        d_rdata_nxt = m_rdata;
                    end
                end
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Requests are ignored here so a requester has one cycle to drop req after ack.
                i_ack_nxt = 1'b0;
                d_ack_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= `GRANT_I;
            last_grant <= `GRANT_D;
            acc_wr     <= 1'b0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            acc_wr     <= acc_wr_nxt;
            m_en       <= m_en_nxt;
            m_we       <= m_we_nxt;
            m_addr     <= m_addr_nxt;
            m_wdata    <= m_wdata_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
        end
    end

endmodule

// File: tb/tb_bfcpu_mem_arbiter.sv
// tb/tb_bfcpu_mem_arbiter.sv - scoreboard bench for bfcpu_mem_arbiter with a behavioural RAM and memory model
module tb_bfcpu_mem_arbiter;

    localparam logic       DIR_WR = 1'b1;
    localparam logic       DIR_RD = 1'b0;
    localparam logic [7:0] PAGE   = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_ack;
    logic [7:0]  i_rdata;
    logic        d_req = 1'b0;
    logic        d_dir = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic        d_ack;
    logic [7:0]  d_rdata;
    logic        m_en;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata = '0;

    bfcpu_mem_arbiter #(.D_PAGE(PAGE), .AW(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            m_rdata <= ram[m_addr];
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] i_exp_q[$];
    logic [7:0] d_exp_q[$];
    int         order_log[$];
    int         i_acks = 0;
    int         d_acks = 0;
    int         we_count = 0;
    logic [15:0] last_we_addr = '0;
    logic [7:0] exp_d_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the per-port expectation whenever an ack is presented.
    initial begin
        logic prev_i, prev_d;
        prev_i = 1'b0;
        prev_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_i = 1'b0;
                prev_d = 1'b0;
            end else begin
                if (i_ack || d_ack) check("ack_exclusive", 32'(i_ack & d_ack), 0);
                if (i_ack) begin
                    check("i_ack_pulse", 32'(prev_i), 0);
                    i_acks++;
                    order_log.push_back(0);
                    if (i_exp_q.size() == 0) check("i_unexpected_ack", i_exp_q.size(), 1);
                    else check("i_rdata", i_rdata, i_exp_q.pop_front());
                end
                if (d_ack) begin
                    check("d_ack_pulse", 32'(prev_d), 0);
                    d_acks++;
                    order_log.push_back(1);
                    if (d_exp_q.size() == 0) check("d_unexpected_ack", d_exp_q.size(), 1);
                    else check("d_rdata", d_rdata, d_exp_q.pop_front());
                end
                if (m_we) begin
                    we_count++;
                    last_we_addr = m_addr;
                end
                prev_i = i_ack;
                prev_d = d_ack;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_d, input int maxc, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(is_d ? d_ack : i_ack) && lat < maxc);
        if (!(is_d ? d_ack : i_ack)) check(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'(is_d ? d_ack : i_ack), 1);
    endtask

    task automatic i_fetch(input logic [15:0] a, input int maxc, output int lat);
        i_exp_q.push_back(ref_mem[a]);
        i_addr = a;
        i_req  = 1'b1;
        wait_ack(1'b0, maxc, lat);
        i_req  = 1'b0;
    endtask

    task automatic d_access(input logic dir, input logic [7:0] a, input logic [7:0] wd,
                            input int maxc, output int lat);
        if (dir == DIR_WR) ref_mem[{PAGE, a}] = wd;
        else exp_d_rdata = ref_mem[{PAGE, a}];
        d_exp_q.push_back(exp_d_rdata);
        d_dir   = dir;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        wait_ack(1'b1, maxc, lat);
        d_req   = 1'b0;
    endtask

    function automatic logic [15:0] rand_i_addr();
        return {8'($urandom_range(0, 254)), 8'($urandom)};
    endfunction

    initial begin
        int li, ld, base, cnt0;
        logic [7:0] v;
        for (int k = 0; k < 65536; k++) begin
            v = 8'($urandom);
            ram[k] = v;
            ref_mem[k] = v;
        end
        ram[16'h0010] = 8'h2B;
        ref_mem[16'h0010] = 8'h2B;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_en", 32'(m_en), 0);
        check("rst_m_we", 32'(m_we), 0);
        check("rst_m_addr", 32'(m_addr), 0);
        check("rst_m_wdata", 32'(m_wdata), 0);
        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_i_rdata", 32'(i_rdata), 0);
        check("rst_d_rdata", 32'(d_rdata), 0);
        rst = 1'b0;

        // Simultaneous requests straight out of reset.
        fork
            i_fetch(16'h0010, 40, li);
            d_access(DIR_RD, 8'h07, 8'h00, 40, ld);
        join
`ifdef BFCPU_ARB_DATA_PRIO_EN
        check("tie_d_lat", li > ld, 1);
        check("tie_d_first_lat", ld, 3);
`else
        check("tie_i_lat", li, 3);
        check("tie_d_lat", ld, 7);
`endif

        // Single fetch.
        idle(2);
        cnt0 = d_acks;
        i_fetch(16'h0010, 20, li);
        check("fetch_lat", li, 3);
        check("fetch_i_rdata", i_rdata, 8'h2B);
        @(negedge clk);
        check("fetch_no_d_ack", d_acks, cnt0);

        // Data write then read back.
        idle(2);
        cnt0 = we_count;
        d_access(DIR_WR, 8'h05, 8'hA5, 20, ld);
        check("wr_lat", ld, 3);
        check("wr_d_rdata_hold", d_rdata, exp_d_rdata);
        check("wr_m_we_pulses", we_count - cnt0, 1);
        check("wr_m_addr", last_we_addr, 16'hFF05);
        idle(2);
        d_access(DIR_RD, 8'h05, 8'h00, 20, ld);
        check("rd_lat", ld, 3);
        check("rd_d_rdata", d_rdata, 8'hA5);

        // Both ports requesting continuously.
        idle(2);
        base = order_log.size();
`ifdef BFCPU_ARB_DATA_PRIO_EN
        fork
            i_fetch(rand_i_addr(), 60, li);
            for (int k = 0; k < 3; k++) d_access(DIR_RD, 8'($urandom), 8'h00, 20, ld);
        join
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("prio_d_first", order_log[base + k], 1);
        check("prio_i_last", order_log[base + 3], 0);
`else
        fork
            for (int k = 0; k < 4; k++) i_fetch(rand_i_addr(), 20, li);
            for (int k = 0; k < 4; k++) d_access(1'($urandom), 8'($urandom), 8'($urandom), 20, ld);
        join
        @(negedge clk);
        for (int k = 0; k < 8; k++) check("rr_alternate", order_log[base + k], k % 2);
`endif

        // Request held through DONE starts a second access.
        idle(2);
        cnt0 = i_acks;
        i_exp_q.push_back(ref_mem[16'h0123]);
        i_exp_q.push_back(ref_mem[16'h0123]);
        i_addr = 16'h0123;
        i_req  = 1'b1;
        wait_ack(1'b0, 20, li);
        check("hold_first_lat", li, 3);
        idle(1);
        check("hold_no_double_ack", 32'(i_ack), 0);
        idle(1);
        i_req = 1'b0;
        wait_ack(1'b0, 20, li);
        check("hold_second_lat", li, 2);
        @(negedge clk);
        check("hold_ack_count", i_acks - cnt0, 2);

        // Asynchronous reset while the access is in ISSUE.
        idle(2);
        d_dir  = DIR_RD;
        d_addr = 8'h05;
        d_req  = 1'b1;
        idle(1);
        check("issue_m_en", 32'(m_en), 1);
        rst = 1'b1;
        #1;
        check("arst_m_en", 32'(m_en), 0);
        check("arst_m_we", 32'(m_we), 0);
        check("arst_i_ack", 32'(i_ack), 0);
        check("arst_d_ack", 32'(d_ack), 0);
        check("arst_i_rdata", 32'(i_rdata), 0);
        check("arst_d_rdata", 32'(d_rdata), 0);
        i_exp_q.delete();
        d_exp_q.delete();
        exp_d_rdata = ref_mem[16'hFF05];
        d_exp_q.push_back(exp_d_rdata);
        idle(1);
        rst = 1'b0;
        wait_ack(1'b1, 20, ld);
        d_req = 1'b0;
        check("post_rst_lat", ld, 3);
        check("post_rst_d_rdata", d_rdata, 8'hA5);

        // Randomised traffic on both ports.
        idle(2);
        fork
            for (int k = 0; k < 30; k++) begin
                int lat;
                idle($urandom_range(0, 3));
                i_fetch(rand_i_addr(), 200, lat);
`ifndef BFCPU_ARB_DATA_PRIO_EN
                check("i_wait_bound", 32'(lat <= 8), 1);
`endif
            end
            for (int k = 0; k < 30; k++) begin
                int lat;
                idle($urandom_range(0, 3));
                d_access(1'($urandom), 8'($urandom), 8'($urandom), 200, lat);
                check("d_wait_bound", 32'(lat <= 8), 1);
            end
        join
        idle(3);
        check("i_queue_drained", i_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
